// File: rtl/reg_serial_tx.sv
`timescale 1ns/1ps
// Framed LSB-first serial transmitter (start, data, [parity], stop) fed by a one-entry holding register.
// Defining REG_SERIAL_TX_PARITY_EN adds an even-parity bit after the data bits.
module reg_serial_tx #(
  parameter int W          = 3,
  parameter int BIT_CYCLES = 1
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic [W-1:0] D,
  input  logic         Load,
  output logic         Ready,
  output logic         SerOut,
  output logic         Busy
);

  localparam int IDX_W = (W > 1) ? $clog2(W) : 1;
  localparam int CYC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(W - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
  localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(BIT_CYCLES - 1);
  localparam logic [CYC_W-1:0] CYC_ONE  = CYC_W'(1);
  localparam logic [CYC_W-1:0] CYC_ZERO = CYC_W'(0);

`ifdef REG_SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  function automatic logic parity_step(input logic acc, input logic data_bit);
    return acc ^ data_bit;
  endfunction
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd4
  } state_t;
`endif

  state_t           state_r, state_s;
  logic [W-1:0]     hold_data_r, hold_data_s;
  logic             hold_valid_r, hold_valid_s;
  logic [W-1:0]     shift_r, shift_s;
  logic [IDX_W-1:0] idx_r, idx_s;
  logic [CYC_W-1:0] cyc_r, cyc_s;
  logic             ser_r, ser_s;
  logic             busy_r, busy_s;
  logic             drain_s, accept_s, bit_done_s;
`ifdef REG_SERIAL_TX_PARITY_EN
  logic             par_r, par_s;
`endif

  // Frame sequencing: each bit lasts BIT_CYCLES; STOP can chain straight into START.
  always_comb begin
    state_s    = state_r;
    shift_s    = shift_r;
    idx_s      = idx_r;
    cyc_s      = cyc_r;
    drain_s    = 1'b0;
`ifdef REG_SERIAL_TX_PARITY_EN
    par_s      = par_r;
`endif
    bit_done_s = (cyc_r == LAST_CYC);
    case (state_r)
      ST_IDLE: begin
        if (hold_valid_r) begin
          state_s = ST_START;
          shift_s = hold_data_r;
          drain_s = 1'b1;
          cyc_s   = CYC_ZERO;
`ifdef REG_SERIAL_TX_PARITY_EN
          par_s   = 1'b0;
`endif
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_done_s) begin
          state_s = ST_DATA;
          idx_s   = IDX_ZERO;
          cyc_s   = CYC_ZERO;
        end else begin
          cyc_s = cyc_r + CYC_ONE;
        end
      end
      ST_DATA: begin
        if (bit_done_s) begin
          cyc_s = CYC_ZERO;
`ifdef REG_SERIAL_TX_PARITY_EN
          par_s = parity_step(par_r, shift_r[idx_r]);
`endif
          if (idx_r == LAST_IDX) begin
`ifdef REG_SERIAL_TX_PARITY_EN
            state_s = ST_PARITY;
`else
            state_s = ST_STOP;
`endif
          end else begin
            idx_s = idx_r + IDX_ONE;
          end
        end else begin
          cyc_s = cyc_r + CYC_ONE;
        end
      end
`ifdef REG_SERIAL_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_done_s) begin
          state_s = ST_STOP;
          cyc_s   = CYC_ZERO;
        end else begin
          cyc_s = cyc_r + CYC_ONE;
        end
      end
`endif
      ST_STOP: begin
        if (bit_done_s) begin
          cyc_s = CYC_ZERO;
          if (hold_valid_r) begin
            state_s = ST_START;
            shift_s = hold_data_r;
            drain_s = 1'b1;
`ifdef REG_SERIAL_TX_PARITY_EN
            par_s   = 1'b0;
`endif
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          cyc_s = cyc_r + CYC_ONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cyc_s   = CYC_ZERO;
      end
    endcase
  end

  // Line level is computed from the next state so SerOut can be a plain flop.
  always_comb begin
    ser_s  = 1'b1;
    busy_s = (state_s != ST_IDLE);
    case (state_s)
      ST_IDLE:   ser_s = 1'b1;
      ST_START:  ser_s = 1'b0;
      ST_DATA:   ser_s = shift_s[idx_s];
`ifdef REG_SERIAL_TX_PARITY_EN
      ST_PARITY: ser_s = par_s;
`endif
      ST_STOP:   ser_s = 1'b1;
      default:   ser_s = 1'b1;
    endcase
  end

  // Holding register: accept only while empty; a drain edge never accepts.
  always_comb begin
    accept_s = Load & ~hold_valid_r;
    if (drain_s) begin
      hold_valid_s = 1'b0;
    end else if (accept_s) begin
      hold_valid_s = 1'b1;
    end else begin
      hold_valid_s = hold_valid_r;
    end
    if (accept_s) begin
      hold_data_s = D;
    end else begin
      hold_data_s = hold_data_r;
    end
  end

  // State and datapath registers; reset aborts any frame and drops the held word.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r      <= ST_IDLE;
      hold_data_r  <= {W{1'b0}};
      hold_valid_r <= 1'b0;
      shift_r      <= {W{1'b0}};
      idx_r        <= IDX_ZERO;
      cyc_r        <= CYC_ZERO;
      ser_r        <= 1'b1;
      busy_r       <= 1'b0;
`ifdef REG_SERIAL_TX_PARITY_EN
      par_r        <= 1'b0;
`endif
    end else begin
      state_r      <= state_s;
      hold_data_r  <= hold_data_s;
      hold_valid_r <= hold_valid_s;
      shift_r      <= shift_s;
      idx_r        <= idx_s;
      cyc_r        <= cyc_s;
      ser_r        <= ser_s;
      busy_r       <= busy_s;
`ifdef REG_SERIAL_TX_PARITY_EN
      par_r        <= par_s;
`endif
    end
  end

  assign Ready  = ~hold_valid_r;
  assign SerOut = ser_r;
  assign Busy   = busy_r;

endmodule

// File: tb/tb_reg_serial_tx.sv
`timescale 1ns/1ps
// Self-checking bench for reg_serial_tx: a frame-level model fills per-cycle expectation queues,
// and scenario tasks add their own checks on handshake timing and frame shapes.
module tb_reg_serial_tx;

  localparam int W   = 3;
  localparam int BC4 = 4;
`ifdef REG_SERIAL_TX_PARITY_EN
  localparam int PAR = 1;
  localparam logic [7:0]  EXP_101 = 8'h2A;
  localparam logic [7:0]  EXP_011 = 8'h26;
  localparam logic [7:0]  EXP_111 = 8'h3E;
  localparam logic [7:0]  EXP_BC  = 8'h34;
  localparam logic [15:0] EXP_B2B = 16'h0B32;
  localparam logic [7:0]  EXP_COL = 8'h38;
`else
  localparam int PAR = 0;
  localparam logic [7:0]  EXP_101 = 8'h1A;
  localparam logic [7:0]  EXP_011 = 8'h16;
  localparam logic [7:0]  EXP_111 = 8'h1E;
  localparam logic [7:0]  EXP_BC  = 8'h14;
  localparam logic [15:0] EXP_B2B = 16'h0392;
  localparam logic [7:0]  EXP_COL = 8'h18;
`endif
  localparam int FL = W + 2 + PAR;

  logic         CLK   = 1'b0;
  logic         RST_N = 1'b0;
  logic [W-1:0] D     = 3'b000;
  logic [W-1:0] D4    = 3'b000;
  logic         Load  = 1'b0;
  logic         Load4 = 1'b0;
  logic         Ready, SerOut, Busy;
  logic         ready4, ser4, busy4;

  int           vectors     = 0;
  int           miscompares = 0;
  bit           exp_q[$];
  bit           exp4_q[$];
  logic         m_hv  = 1'b0;
  logic         m_hv4 = 1'b0;
  logic [W-1:0] m_hold  = 3'b000;
  logic [W-1:0] m_hold4 = 3'b000;
  bit           sb_en   = 1'b0;
  bit           e_ser, e_busy, e_ser4, e_busy4;

  reg_serial_tx #(.W(W), .BIT_CYCLES(1)) dut (
    .CLK(CLK), .RST_N(RST_N), .D(D), .Load(Load),
    .Ready(Ready), .SerOut(SerOut), .Busy(Busy)
  );

  reg_serial_tx #(.W(W), .BIT_CYCLES(BC4)) dut4 (
    .CLK(CLK), .RST_N(RST_N), .D(D4), .Load(Load4),
    .Ready(ready4), .SerOut(ser4), .Busy(busy4)
  );

  initial forever #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit frame_bit(input logic [W-1:0] d, input int i);
    if (i == 0) return 1'b0;
    if (i <= W) return d[i-1];
    if (PAR == 1 && i == W + 1) return ^d;
    return 1'b1;
  endfunction

  // Reference model: holding register per DUT; a held word becomes a frame once the line is free.
  initial forever begin
    @(posedge CLK or negedge RST_N);
    if (!RST_N) begin
      exp_q.delete();
      exp4_q.delete();
      m_hv  = 1'b0;
      m_hv4 = 1'b0;
    end else begin
      if (exp_q.size() == 0 && m_hv) begin
        for (int i = 0; i < FL; i++) exp_q.push_back(frame_bit(m_hold, i));
        m_hv = 1'b0;
      end else if (Load && !m_hv) begin
        m_hv   = 1'b1;
        m_hold = D;
      end
      if (exp4_q.size() == 0 && m_hv4) begin
        for (int i = 0; i < FL; i++)
          for (int r = 0; r < BC4; r++) exp4_q.push_back(frame_bit(m_hold4, i));
        m_hv4 = 1'b0;
      end else if (Load4 && !m_hv4) begin
        m_hv4   = 1'b1;
        m_hold4 = D4;
      end
    end
  end

  // Scoreboard: every cycle pops one expected line bit per DUT (idle line when empty).
  initial forever begin
    @(negedge CLK);
    if (RST_N && sb_en) begin
      if (exp_q.size() > 0) begin e_ser = exp_q.pop_front(); e_busy = 1'b1; end
      else begin e_ser = 1'b1; e_busy = 1'b0; end
      if (exp4_q.size() > 0) begin e_ser4 = exp4_q.pop_front(); e_busy4 = 1'b1; end
      else begin e_ser4 = 1'b1; e_busy4 = 1'b0; end
      vectors++;
      if (SerOut !== e_ser) begin miscompares++; $display("FAIL sb_serout t=%0t got=%b required=%b", $time, SerOut, e_ser); end
      vectors++;
      if (Busy !== e_busy) begin miscompares++; $display("FAIL sb_busy t=%0t got=%b required=%b", $time, Busy, e_busy); end
      vectors++;
      if (Ready !== !m_hv) begin miscompares++; $display("FAIL sb_ready t=%0t got=%b required=%b", $time, Ready, !m_hv); end
      vectors++;
      if (ser4 !== e_ser4) begin miscompares++; $display("FAIL sb_serout4 t=%0t got=%b required=%b", $time, ser4, e_ser4); end
      vectors++;
      if (busy4 !== e_busy4) begin miscompares++; $display("FAIL sb_busy4 t=%0t got=%b required=%b", $time, busy4, e_busy4); end
      vectors++;
      if (ready4 !== !m_hv4) begin miscompares++; $display("FAIL sb_ready4 t=%0t got=%b required=%b", $time, ready4, !m_hv4); end
    end
  end

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge CLK);
      if (exp_q.size() == 0 && exp4_q.size() == 0 && !m_hv && !m_hv4) ok = 1'b1;
    end
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    sb_en = 1'b0;
    repeat (3) @(negedge CLK);
    vectors++; if (SerOut !== 1'b1) begin miscompares++; $display("FAIL reset_serout got=%b required=1", SerOut); end
    vectors++; if (Ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got=%b required=1", Ready); end
    vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b required=0", Busy); end
    vectors++; if (ser4 !== 1'b1) begin miscompares++; $display("FAIL reset_serout4 got=%b required=1", ser4); end
    RST_N = 1'b1;
    sb_en = 1'b1;
    @(negedge CLK);
    vectors++; if (SerOut !== 1'b1 || Busy !== 1'b0) begin miscompares++; $display("FAIL post_reset_idle got=%b%b required=10", SerOut, Busy); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int busy_cnt;
    wait_idle(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL midrst_idle_timeout got=busy required=idle"); end
    D = 3'b101; Load = 1'b1;
    @(negedge CLK);
    Load = 1'b0;
    @(negedge CLK);
    D = 3'b110; Load = 1'b1;
    @(negedge CLK);
    Load = 1'b0;
    vectors++; if (Busy !== 1'b1 || Ready !== 1'b0) begin miscompares++; $display("FAIL midrst_precond got=%b%b required=10", Busy, Ready); end
    #2 RST_N = 1'b0;
    #1;
    vectors++; if (SerOut !== 1'b1) begin miscompares++; $display("FAIL midrst_serout got=%b required=1", SerOut); end
    vectors++; if (Ready !== 1'b1) begin miscompares++; $display("FAIL midrst_ready got=%b required=1", Ready); end
    vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy got=%b required=0", Busy); end
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    busy_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      if (Busy !== 1'b0) busy_cnt++;
    end
    vectors++; if (busy_cnt != 0) begin miscompares++; $display("FAIL midrst_no_frame got=%0d busy cycles required=0", busy_cnt); end
  endtask

  task automatic test_single_frame(input logic [W-1:0] d, input logic [7:0] exp_bits, input string name);
    bit ok, done;
    int n;
    logic [7:0] got;
    wait_idle(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL %s_idle_timeout got=busy required=idle", name); end
    D = d; Load = 1'b1;
    vectors++; if (Ready !== 1'b1) begin miscompares++; $display("FAIL %s_ready_before got=%b required=1", name, Ready); end
    @(negedge CLK);
    Load = 1'b0; D = ~d;
    vectors++; if (Ready !== 1'b0) begin miscompares++; $display("FAIL %s_ready_accepted got=%b required=0", name, Ready); end
    n = 0; got = 8'h00; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (c == 1) begin
        vectors++; if (Ready !== 1'b1) begin miscompares++; $display("FAIL %s_ready_reopen got=%b required=1", name, Ready); end
      end
      if (Busy === 1'b1) begin
        if (n < 8) got[n] = SerOut;
        n++;
      end else if (n > 0) begin
        done = 1'b1;
      end
      if (!done) @(negedge CLK);
    end
    vectors++; if (n != FL) begin miscompares++; $display("FAIL %s_busy_len got=%0d required=%0d", name, n, FL); end
    vectors++; if (got !== exp_bits) begin miscompares++; $display("FAIL %s_bits got=%b required=%b", name, got, exp_bits); end
  endtask

  task automatic test_back_to_back();
    bit ok, started, ended;
    int run;
    logic [15:0] got;
    wait_idle(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL b2b_idle_timeout got=busy required=idle"); end
    run = 0; got = 16'h0000; started = 1'b0; ended = 1'b0;
    for (int c = 0; c < 2 * FL + 8; c++) begin
      if (Busy === 1'b1 && !ended) begin
        if (run < 16) got[run] = SerOut;
        run++;
        started = 1'b1;
      end else if (started) begin
        ended = 1'b1;
      end
      if (c == 1) begin vectors++; if (Ready !== 1'b0) begin miscompares++; $display("FAIL b2b_ready_c1 got=%b required=0", Ready); end end
      if (c == 2) begin vectors++; if (Ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_c2 got=%b required=1", Ready); end end
      if (c == 3) begin vectors++; if (Ready !== 1'b0) begin miscompares++; $display("FAIL b2b_ready_c3 got=%b required=0", Ready); end end
      if (c == 0) begin D = 3'b001; Load = 1'b1; end
      if (c == 1) D = 3'b110;
      if (c == 3) D = 3'b111;
      if (c == 4) Load = 1'b0;
      @(negedge CLK);
    end
    vectors++; if (run != 2 * FL) begin miscompares++; $display("FAIL b2b_busy_run got=%0d required=%0d", run, 2 * FL); end
    vectors++; if (got !== EXP_B2B) begin miscompares++; $display("FAIL b2b_bits got=%b required=%b", got, EXP_B2B); end
  endtask

  task automatic test_bit_cycles();
    bit ok, done;
    int n;
    logic [31:0] got;
    logic [7:0]  eb;
    wait_idle(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL bc_idle_timeout got=busy required=idle"); end
    D4 = 3'b010; Load4 = 1'b1;
    @(negedge CLK);
    Load4 = 1'b0; D4 = 3'b101;
    n = 0; got = 32'h0; done = 1'b0; eb = EXP_BC;
    for (int c = 0; c < 80 && !done; c++) begin
      if (busy4 === 1'b1) begin
        if (n < 32) got[n] = ser4;
        n++;
      end else if (n > 0) begin
        done = 1'b1;
      end
      if (!done) @(negedge CLK);
    end
    vectors++; if (n != FL * BC4) begin miscompares++; $display("FAIL bc_frame_len got=%0d required=%0d", n, FL * BC4); end
    for (int i = 0; i < n && i < FL * BC4; i++) begin
      vectors++;
      if (got[i] !== eb[i / BC4]) begin miscompares++; $display("FAIL bc_bit cycle=%0d got=%b required=%b", i, got[i], eb[i / BC4]); end
    end
  endtask

  task automatic test_collision();
    bit ok, started, ended;
    int run;
    logic [31:0] got;
    logic [7:0]  cb;
    wait_idle(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL col_idle_timeout got=busy required=idle"); end
    run = 0; got = 32'h0; started = 1'b0; ended = 1'b0;
    for (int c = 0; c < 3 * FL + 8; c++) begin
      if (Busy === 1'b1 && !ended) begin
        if (run < 32) got[run] = SerOut;
        run++;
        started = 1'b1;
      end else if (started) begin
        ended = 1'b1;
      end
      if (c == FL + 1) begin vectors++; if (Ready !== 1'b0) begin miscompares++; $display("FAIL col_drain_edge_ready got=%b required=0", Ready); end end
      if (c == FL + 2) begin vectors++; if (Ready !== 1'b1) begin miscompares++; $display("FAIL col_ready_after_drain got=%b required=1", Ready); end end
      if (c == FL + 3) begin vectors++; if (Ready !== 1'b0) begin miscompares++; $display("FAIL col_accept_late got=%b required=0", Ready); end end
      if (c == 0) begin D = 3'b011; Load = 1'b1; end
      if (c == 1) Load = 1'b0;
      if (c == 2) begin D = 3'b101; Load = 1'b1; end
      if (c == 3) D = 3'b100;
      if (c == FL + 3) Load = 1'b0;
      @(negedge CLK);
    end
    cb = 8'(got >> (2 * FL));
    vectors++; if (run != 3 * FL) begin miscompares++; $display("FAIL col_busy_run got=%0d required=%0d", run, 3 * FL); end
    vectors++; if (cb !== EXP_COL) begin miscompares++; $display("FAIL col_third_frame got=%b required=%b", cb, EXP_COL); end
  endtask

  initial begin
    bit ok;
    test_reset();
    test_reset_mid_frame();
    test_single_frame(3'b101, EXP_101, "single_101");
    test_single_frame(3'b011, EXP_011, "single_011");
    test_single_frame(3'b111, EXP_111, "single_111");
    test_back_to_back();
    test_bit_cycles();
    test_collision();
    wait_idle(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL final_idle_timeout got=busy required=idle"); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_serial_tx.md
# reg_serial_tx

Parallel-to-serial transmitter for register-transfer words. It accepts a W-bit word from a loaded register through a Load/Ready handshake and buffers it in a one-entry holding register. It then shifts the word out LSB-first on a single framed serial line: start bit, data bits, optional parity bit, stop bit. It is the sending end of the team's serial register-transfer link and sits between a parallel-load register stage and the serial receiver.

## Interface
- W, default 3, data word width in bits (≥1).
- BIT_CYCLES, default 1, clock cycles each serial bit is held on SerOut (≥1).

- CLK  input  1  rising-edge clock.
- RST_N  input  1  asynchronous, active-low reset.
- D  input  W  parallel word to transmit.
- Load  input  1  offer D; the word is accepted on a rising CLK edge where Load && Ready.
- Ready  output  1  holding register empty; a word can be accepted.
- SerOut  output  1  serial line, registered; idles high.
- Busy  output  1  high while a frame is on the line (FSM not IDLE).

## Operation
- Storage:
  - hold_data[W-1:0] and hold_valid.
  - shift[W-1:0] for the data being sent.
  - bit index counter, width clog2(W).
  - cycle counter, counts 0..BIT_CYCLES-1.
  - parity accumulator.
- Ready = !hold_valid. This is combinational from registers only and does not depend on Load.
- Accept: Load && Ready at an edge loads hold_data <= D and sets hold_valid = 1. Load while Ready=0 is ignored, and D is not sampled.
- FSM states: IDLE, START, DATA, PARITY, STOP. PARITY exists only with REG_SERIAL_TX_PARITY_EN.
  - IDLE: SerOut=1. If hold_valid, go to START. On that edge, shift <= hold_data and hold_valid <= 0.
  - START: SerOut=0 for BIT_CYCLES cycles, then go to DATA with index=0.
  - DATA: SerOut=shift[index] for BIT_CYCLES cycles per bit, bits 0 to W-1. After bit W-1, go to PARITY if enabled, otherwise STOP.
  - PARITY: SerOut = XOR of the W data bits (even parity) for BIT_CYCLES cycles, then go to STOP.
  - STOP: SerOut=1 for BIT_CYCLES cycles.
    - If hold_valid at the final STOP cycle, go directly to START and transfer the holding register to shift on that same edge. There is no idle gap.
    - Otherwise go to IDLE.
- Simultaneous events:
  - If the holding register drains on the same edge that Load is high, Ready was 0 that cycle, so the word is not accepted. Ready rises the following cycle.
  - A Load may be accepted during any frame state while hold_valid=0. That word is sent as the next frame.
- D changing after acceptance does not affect the word in flight or in the holding register.

## Timing
- Reset values (asynchronous, while RST_N=0):
  - State=IDLE, SerOut=1, Ready=1, Busy=0.
  - hold_valid=0; shift, counters and parity = 0.
- Reset mid-frame aborts the frame immediately. SerOut goes high asynchronously, and any held word is discarded.
- Latency: a word accepted at edge k with the FSM idle enters START at edge k+1. SerOut=0 is visible from edge k+1.
- Frame length: (W+2) × BIT_CYCLES cycles, or (W+3) × BIT_CYCLES with parity.
- Busy is high from the edge entering START through the last STOP cycle. It stays high across back-to-back frames.
- Throughput: one word per frame length, sustained, when Load is offered whenever Ready=1.

## Configuration
- REG_SERIAL_TX_PARITY_EN defined:
  - The PARITY state is present.
  - One even-parity bit follows the data bits, and the frame is W+3 bits.
- Not defined:
  - No PARITY state and no parity logic.
  - DATA goes directly to STOP, and the frame is W+2 bits.

## Test plan
- Reset: hold RST_N=0 for 3 cycles, then release. Required: SerOut=1, Ready=1, Busy=0. Then assert RST_N=0 mid-DATA. Required: SerOut=1 and Ready=1 immediately, with no further frame.
- Single frame, W=3, BIT_CYCLES=1, parity off: Load D=3'b101 at edge 0. Required:
  - SerOut from edge 1 reads 0,1,0,1,1.
  - Busy high for exactly 5 cycles.
  - Ready low only during cycle 0→1.
- Parity on, D=3'b011: required SerOut 0,1,1,0,0,1. Then D=3'b111: required SerOut 0,1,1,1,1,1.
- Back-to-back: Load 3'b001, then Load 3'b110 as soon as Ready=1. Required:
  - The second frame's start bit immediately follows the first frame's stop bit.
  - Busy never drops between frames.
  - Load asserted while Ready=0 is ignored.
- BIT_CYCLES=4, D=3'b010: required each serial bit held exactly 4 cycles, and frame length 20 cycles with parity off.
- Hold-drain collision: with hold_valid=1 during STOP, hold Load high with D=3'b100. Required:
  - The word is not accepted on the drain edge.
  - It is accepted one cycle later and sent as the following frame.
